accum_bofs_scheduler: RTL

- Shares one accumulation warp looper between N block-offset requesters.
- Round-robin arbitrates the requesters' block-offset (bofs) rdy/ack channels onto the looper's abofs input.
- Records the source of every issued block in an in-order tag FIFO, bounding outstanding blocks to DEPTH.
- Routes the looper's per-block finish handshake back to the requester that owns the oldest block.

---
 rtl/accum_bofs_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/accum_bofs_scheduler.sv
// Round-robin block-offset scheduler for one shared accumulation looper, with in-order finish routing.
// Optional sticky error flag o_err when ACCUM_BOFS_SCHED_ERR_EN is defined.
module accum_bofs_scheduler #(
  parameter int N     = 4,
  parameter int BW    = 32,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_bofs_rdy,
  output logic [N-1:0]         i_bofs_ack,
  input  logic [N-1:0][BW-1:0] i_bofs,
  output logic                 o_abofs_rdy,
  input  logic                 o_abofs_ack,
  output logic [BW-1:0]        o_abofs,
  output logic [IDW-1:0]       o_abofs_src,
  input  logic                 i_fin_rdy,
  output logic                 i_fin_ack,
  output logic [N-1:0]         o_fin_rdy,
  input  logic [N-1:0]         o_fin_ack
`ifdef ACCUM_BOFS_SCHED_ERR_EN
  ,output logic                o_err
`endif
);

  // Every channel: transfer when rdy && ack; producer holds rdy and data until then.
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    abofs_q, abofs_d;
  logic [IDW-1:0]   src_q, src_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   tag_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      count_q, count_d;

  logic             slot_free, nonempty, pop, grant, found;
  logic [IDW-1:0]   win, head;
  int               idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && i_bofs_rdy[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign slot_free = (state_q == ST_EMPTY) || o_abofs_ack;
  assign nonempty  = (count_q != '0);
  assign head      = tag_q[rd_q];
  assign i_fin_ack = nonempty && o_fin_ack[head];
  assign pop       = i_fin_rdy && i_fin_ack;
  // A same-cycle pop frees a tag slot, so a full FIFO can still accept a grant.
  assign grant     = slot_free && ((count_q < DEPTH_C) || pop) && found;

  always_comb begin
    i_bofs_ack = '0;
    if (grant) i_bofs_ack = N'(1) << win;
    for (int j = 0; j < N; j++) begin
      o_fin_rdy[j] = i_fin_rdy && nonempty && (head == IDW'(j));
    end
  end

  always_comb begin
    state_d = state_q;
    abofs_d = abofs_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (grant) begin
      state_d = ST_FULL;
      abofs_d = i_bofs[win];
      src_d   = win;
      ptr_d   = (win == IDW'(N-1)) ? '0 : win + IDW'(1);
      wr_d    = wr_q + AW'(1);
    end else if (state_q == ST_FULL && o_abofs_ack) begin
      state_d = ST_EMPTY;
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({grant, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      abofs_q <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      abofs_q <= abofs_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (grant) tag_q[wr_q] <= win;
    end
  end

  assign o_abofs_rdy = (state_q == ST_FULL);
  assign o_abofs     = abofs_q;
  assign o_abofs_src = src_q;

`ifdef ACCUM_BOFS_SCHED_ERR_EN
  // hold_q marks that the previous cycle was FULL without accept, so abofs_q must not move.
  logic          err_q, err_d, hold_q;
  logic [BW-1:0] prev_q;

  assign err_d = err_q || (i_fin_rdy && !nonempty) || (hold_q && (abofs_q != prev_q));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q  <= 1'b0;
      hold_q <= 1'b0;
      prev_q <= '0;
    end else begin
      err_q  <= err_d;
      hold_q <= (state_q == ST_FULL) && !o_abofs_ack;
      prev_q <= abofs_q;
    end
  end

  assign o_err = err_q;
`endif

endmodule
